trackball_sampler: RTL and testbench

Parametrised multi-player, multi-axis trackball position sampler. It replaces the fixed two-player load/clear/shift strobe scheme with on-chip quadrature decoding, per-channel up/down counters and video-timed snapshot/clear. It sits between the trackball inputs and the CPU input port mux. The snapshot for one player is taken once per 8-pixel group, with players taking video lines in turn, so the CPU reads a stable delta while movement keeps accumulating.

---
 rtl/trackball_sampler.sv | 100 ++++++++++
 tb/tb_trackball_sampler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/trackball_sampler.sv
// trackball_sampler: quadrature decode, per-channel up/down counters and video-timed snapshot/clear.
// Each load event snapshots one player's counters into holding registers and restarts them.
module trackball_sampler #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_AXES = 2,
    parameter int CNT_W = 4,
    parameter bit SATURATE = 1'b0,
    parameter logic [2:0] LOAD_PHASE = 3'd5,
    localparam int CH = NUM_PLAYERS * NUM_AXES,
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic [8:0]                   HC,
    input  logic [7:0]                   VC,
    input  logic [CH-1:0]                quad_a,
    input  logic [CH-1:0]                quad_b,
    input  logic [PW-1:0]                sel,
    output logic [NUM_AXES*CNT_W-1:0]    pos_out,
    output logic [CH-1:0]                err_out,
    output logic                         ld_pulse,
    output logic [PW-1:0]                ld_player
);
    typedef enum logic [1:0] {PRIME0, PRIME1, PRIME2, RUN} state_t;
    state_t state, state_n;
    logic [CH-1:0] a1, a2, b1, b2, pa, pb;
    logic [CNT_W-1:0] hold_all [CH];
    logic run, ld_ev;
    logic [PW-1:0] owner;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= PRIME0;
        else if (ce) state <= state_n;
    always_comb begin
        state_n = (state == RUN) ? RUN : state_t'(state + 2'd1);
        run = (state == RUN);
        ld_ev = ce && run && (HC[2:0] == LOAD_PHASE);
        owner = (NUM_PLAYERS > 1) ? VC[PW-1:0] : '0;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            {a1, a2, b1, b2, pa, pb} <= '0;
        end else if (ce) begin
            a1 <= quad_a;
            a2 <= a1;
            b1 <= quad_b;
            b2 <= b1;
            pa <= a2;
            pb <= b2;
        end
    for (genvar c = 0; c < CH; c++) begin : g_ch
        localparam int P = c / NUM_AXES;
        logic fwd, bwd, bad, own;
        logic [CNT_W:0] sum;
        logic [CNT_W-1:0] dlt, nxt, cnt, hold;
        logic err;
        // Gray order 00->01->11->10: the successor of {a,b} is {b,~a}.
        always_comb begin
            fwd = ({a2[c], b2[c]} == {pb[c], ~pa[c]});
            bwd = ({pa[c], pb[c]} == {b2[c], ~a2[c]});
            bad = (a2[c] ^ pa[c]) & (b2[c] ^ pb[c]);
            dlt = fwd ? CNT_W'(1) : bwd ? '1 : '0;
            sum = {cnt[CNT_W-1], cnt} + {dlt[CNT_W-1], dlt};
            nxt = (SATURATE && (sum[CNT_W] != sum[CNT_W-1])) ? {sum[CNT_W], {(CNT_W-1){~sum[CNT_W]}}} : sum[CNT_W-1:0];
            own = ld_ev && (owner == PW'(P));
        end
        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                cnt <= '0;
                hold <= '0;
                err <= 1'b0;
            end else if (ce && run) begin
                if (own) begin
                    hold <= cnt;
                    cnt <= dlt;
                    err <= bad;
                end else begin
                    cnt <= nxt;
                    err <= err | bad;
                end
            end
        assign hold_all[c] = hold;
        assign err_out[c] = err;
    end
    always_comb begin
        pos_out = '0;
        for (int p = 0; p < NUM_PLAYERS; p++)
            if (sel == PW'(p))
                for (int a = 0; a < NUM_AXES; a++)
                    pos_out[a*CNT_W +: CNT_W] = hold_all[p*NUM_AXES+a];
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ld_pulse <= 1'b0;
            ld_player <= '0;
        end else begin
            ld_pulse <= ld_ev;
            if (ld_ev) ld_player <= owner;
        end
endmodule

// File: tb/tb_trackball_sampler.sv
// tb_trackball_sampler: directed stimulus; expected snapshots are queued and checked on each ld_pulse.
module tb_trackball_sampler;
    typedef struct {
        logic [0:0] pl;
        logic [7:0] pos;
        logic [7:0] pos_s;
        logic [3:0] err;
    } exp_t;
    typedef struct {
        logic [1:0] pl;
        logic [7:0] pos;
    } exp4_t;
    logic clk = 1'b0, reset = 1'b1, ce = 1'b1;
    logic [8:0] HC = '0, hc4 = '0;
    logic [7:0] VC = '0, vc4 = '0;
    logic [3:0] qa = '1, qb = '1;
    logic [7:0] qa4 = '0, qb4 = '0;
    logic [0:0] sel = '0;
    logic [1:0] sel4 = '0;
    logic [7:0] pos, pos_s, pos4, err4;
    logic [3:0] err, err_s;
    logic ldp, ldp_s, ldp4;
    logic [0:0] lpl, lpl_s;
    logic [1:0] lpl4;
    exp_t q[$];
    exp4_t q4[$];
    exp_t em;
    exp4_t em4;
    int errors = 0, checks = 0;
    int ph[4] = '{2, 2, 2, 2};
    logic [1:0] gray[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    always #5 clk = ~clk;
    trackball_sampler dut (.clk(clk), .reset(reset), .ce(ce), .HC(HC), .VC(VC), .quad_a(qa), .quad_b(qb),
        .sel(sel), .pos_out(pos), .err_out(err), .ld_pulse(ldp), .ld_player(lpl));
    trackball_sampler #(.SATURATE(1'b1)) dut_s (.clk(clk), .reset(reset), .ce(ce), .HC(HC), .VC(VC),
        .quad_a(qa), .quad_b(qb), .sel(sel), .pos_out(pos_s), .err_out(err_s), .ld_pulse(ldp_s), .ld_player(lpl_s));
    trackball_sampler #(.NUM_PLAYERS(4)) dut4 (.clk(clk), .reset(reset), .ce(ce), .HC(hc4), .VC(vc4),
        .quad_a(qa4), .quad_b(qb4), .sel(sel4), .pos_out(pos4), .err_out(err4), .ld_pulse(ldp4), .ld_player(lpl4));
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, want);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic quad(input int ch, input logic [1:0] v);
        qa[ch] = v[1];
        qb[ch] = v[0];
    endtask
    task automatic move(input int ch, input int n);
        for (int i = 0; i < (n < 0 ? -n : n); i++) begin
            ph[ch] = (ph[ch] + (n < 0 ? 3 : 1)) % 4;
            quad(ch, gray[ph[ch]]);
            tick(1);
        end
    endtask
    task automatic load(input logic [0:0] pl, input logic [7:0] p, input logic [7:0] ps, input logic [3:0] e);
        q.push_back('{pl: pl, pos: p, pos_s: ps, err: e});
        VC = {7'd0, pl};
        sel = pl;
        HC = 9'd5;
        tick(1);
        HC = '0;
        tick(1);
    endtask
    always @(negedge clk)
        if (ldp) begin
            if (q.size() == 0) chk("unexpected_ld_pulse", 1, 0);
            else begin
                em = q.pop_front();
                chk("ld_player", 32'(lpl), 32'(em.pl));
                chk("pos_out", 32'(pos), 32'(em.pos));
                chk("pos_out_sat", 32'(pos_s), 32'(em.pos_s));
                chk("err_out", 32'(err), 32'(em.err));
            end
        end
    always @(negedge clk)
        if (ldp4) begin
            if (q4.size() == 0) chk("unexpected_ld_pulse4", 1, 0);
            else begin
                em4 = q4.pop_front();
                chk("ld_player4", 32'(lpl4), 32'(em4.pl));
                chk("pos_out4", 32'(pos4), 32'(em4.pos));
            end
        end
    initial begin
        tick(3);
        chk("rst_pos", 32'(pos), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ldp", 32'(ldp), 0);
        chk("rst_ldplayer", 32'(lpl), 0);
        chk("rst_pos_sat", 32'(pos_s), 0);
        reset = 1'b0;
        tick(5);
        chk("prime_err", 32'(err), 0);
        load(1'b0, 8'h00, 8'h00, 4'h0);
        load(1'b1, 8'h00, 8'h00, 4'h0);
        move(0, -2);
        tick(4);
        load(1'b0, 8'h0E, 8'h0E, 4'h0);
        move(0, 6);
        tick(4);
        load(1'b0, 8'h06, 8'h06, 4'h0);
        load(1'b0, 8'h00, 8'h00, 4'h0);
        move(0, 9);
        tick(4);
        load(1'b0, 8'h09, 8'h07, 4'h0);
        move(3, -10);
        tick(4);
        load(1'b1, 8'h60, 8'h80, 4'h0);
        move(0, 3);
        tick(4);
        ph[0] = 3;
        quad(0, gray[3]);
        tick(2);
        load(1'b0, 8'h03, 8'h03, 4'h0);
        tick(4);
        load(1'b0, 8'h01, 8'h01, 4'h0);
        ph[1] = 0;
        quad(1, gray[0]);
        tick(4);
        chk("illegal_sticky", 32'(err), 32'h2);
        load(1'b1, 8'h00, 8'h00, 4'h2);
        load(1'b0, 8'h00, 8'h00, 4'h0);
        ph[2] = 0;
        quad(2, gray[0]);
        tick(2);
        load(1'b1, 8'h00, 8'h00, 4'h4);
        load(1'b1, 8'h00, 8'h00, 4'h0);
        ce = 1'b0;
        HC = 9'd5;
        move(0, 1);
        tick(4);
        HC = '0;
        ce = 1'b1;
        tick(4);
        load(1'b0, 8'h01, 8'h01, 4'h0);
        move(0, 1);
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("midrst_pos", 32'(pos), 0);
        chk("midrst_err", 32'(err), 0);
        ph[0] = 3;
        quad(0, gray[3]);
        tick(2);
        reset = 1'b0;
        tick(5);
        load(1'b0, 8'h00, 8'h00, 4'h0);
        qb4[4] = 1'b1;
        tick(1);
        qa4[4] = 1'b1;
        tick(5);
        for (int v = 0; v < 8; v++) begin
            q4.push_back('{pl: 2'(v), pos: (v == 2) ? 8'h02 : 8'h00});
            vc4 = 8'(v);
            sel4 = 2'(v);
            hc4 = 9'd5;
            tick(1);
            hc4 = '0;
            tick(1);
        end
        tick(3);
        chk("queue_drained", 32'(q.size()), 0);
        chk("queue4_drained", 32'(q4.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
